// File: rtl/vga_pkg.sv
// Shared VGA timing constants, colour type and widths for the 640x480@60 raster.
package vga_pkg;

   // Standard 640x480@60 timing: horizontal in pixels, vertical in lines
   localparam int H_ACTIVE_STD = 640;
   localparam int H_FP_STD     = 16;
   localparam int H_SYNC_STD   = 96;
   localparam int H_BP_STD     = 48;
   localparam int V_ACTIVE_STD = 480;
   localparam int V_FP_STD     = 10;
   localparam int V_SYNC_STD   = 2;
   localparam int V_BP_STD     = 33;

   localparam int H_TOTAL = H_ACTIVE_STD + H_FP_STD + H_SYNC_STD + H_BP_STD;  // 800
   localparam int V_TOTAL = V_ACTIVE_STD + V_FP_STD + V_SYNC_STD + V_BP_STD;  // 525

   // Widths shared with the picture generator
   localparam int CNT_W   = 10;
   localparam int PIX_X_W = 10;
   localparam int PIX_Y_W = 9;
   localparam int RGB_W   = 12;

   typedef logic [RGB_W-1:0] rgb_t;

   // Map an internal "sync active" flag onto the pin level
   function automatic logic sync_level(input logic raw, input logic pol);
      return raw ? pol : ~pol;
   endfunction

endpackage

// File: rtl/vga_timing_ctrl_pix_tick_gen.sv
// Pixel-rate divider: one-clk tick every CLK_DIV system clocks.
module pix_tick_gen
#(
   parameter int CLK_DIV = 4
)
(
   input  logic clk,
   input  logic rst,
   output logic tick
);

   // A 1-bit counter is kept even for CLK_DIV = 1; it simply stays at 0
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_cnt;

   // Count 0..CLK_DIV-1 and wrap; reset discards any partial pixel period
   always_ff @(posedge clk) begin
      if (rst)
         div_cnt <= '0;
      else if (div_cnt == LAST)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + 1'b1;
   end

   assign tick = (div_cnt == LAST);

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: drives the coordinate bus to the picture
// generator and registers its colour together with hsync/vsync.
module vga_timing_ctrl
   import vga_pkg::*;
#(
   parameter int   CLK_DIV  = 4,
   parameter int   H_ACTIVE = H_ACTIVE_STD,
   parameter int   H_FP     = H_FP_STD,
   parameter int   H_SYNC   = H_SYNC_STD,
   parameter int   H_BP     = H_BP_STD,
   parameter int   V_ACTIVE = V_ACTIVE_STD,
   parameter int   V_FP     = V_FP_STD,
   parameter int   V_SYNC   = V_SYNC_STD,
   parameter int   V_BP     = V_BP_STD,
   parameter logic SYNC_POL = 1'b0
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic [RGB_W-1:0]   rgb_in,
   output logic [PIX_X_W-1:0] pix_x,
   output logic [PIX_Y_W-1:0] pix_y,
   output logic               pix_req,
   output logic               pix_tick,
   output logic               hsync,
   output logic               vsync,
   output logic [RGB_W-1:0]   rgb_out,
   output logic               frame_start
);

   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOT - 1);
   localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOT - 1);
   localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             h_last;
   logic             v_last;
   logic             hsync_raw;
   logic             vsync_raw;

   pix_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (pix_tick)
   );

   assign h_last = (h_cnt == H_LAST);
   assign v_last = (v_cnt == V_LAST);

   // Raster position: h advances per pixel, v advances on each line wrap
   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pix_tick) begin
         if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end

   // Region decode; sync windows sit after the front porch
   assign hsync_raw = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
   assign vsync_raw = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

   // Coordinate bus is zeroed outside the active area so the generator
   // never sees blanking positions
   assign pix_req = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign pix_x   = pix_req ? h_cnt : '0;
   assign pix_y   = pix_req ? v_cnt[PIX_Y_W-1:0] : '0;

   // Frame wrap pulse; the start of the very first frame has no predecessor
   assign frame_start = pix_tick && h_last && v_last;

   // Output stage: colour and syncs share one pixel of latency so they
   // leave the chip mutually aligned
   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_out <= '0;
         hsync   <= ~SYNC_POL;
         vsync   <= ~SYNC_POL;
      end else if (pix_tick) begin
         rgb_out <= pix_req ? rgb_in : '0;
         hsync   <= sync_level(hsync_raw, SYNC_POL);
         vsync   <= sync_level(vsync_raw, SYNC_POL);
      end
   end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: three instances (standard timing, shrunk timing
// for whole-frame sweeps, CLK_DIV = 1) against a tick-count raster model.
module tb_vga_timing_ctrl;
   import vga_pkg::*;

   typedef struct {
      int d, ha, hf, hs, hb, va, vf, vs, vb;
   } tp_t;

   typedef struct {
      int h, v;
      bit req, hraw, vraw;
   } pos_t;

   localparam tp_t P_FULL  = '{4, 640, 16, 96, 48, 480, 10, 2, 33};
   localparam tp_t P_SMALL = '{2, 16, 2, 4, 3, 10, 2, 2, 3};
   localparam tp_t P_DIV1  = '{1, 640, 16, 96, 48, 480, 10, 2, 33};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [11:0] rgb_in = '0;

   logic [9:0]  ox   [3];
   logic [8:0]  oy   [3];
   logic        oreq [3];
   logic        otick[3];
   logic        ohs  [3];
   logic        ovs  [3];
   logic [11:0] orgb [3];
   logic        ofs  [3];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   vga_timing_ctrl #(.CLK_DIV(4)) dut_full (
      .clk(clk), .rst(rst), .rgb_in(rgb_in), .pix_x(ox[0]), .pix_y(oy[0]),
      .pix_req(oreq[0]), .pix_tick(otick[0]), .hsync(ohs[0]), .vsync(ovs[0]),
      .rgb_out(orgb[0]), .frame_start(ofs[0]));

   vga_timing_ctrl #(.CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
                     .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3)) dut_small (
      .clk(clk), .rst(rst), .rgb_in(rgb_in), .pix_x(ox[1]), .pix_y(oy[1]),
      .pix_req(oreq[1]), .pix_tick(otick[1]), .hsync(ohs[1]), .vsync(ovs[1]),
      .rgb_out(orgb[1]), .frame_start(ofs[1]));

   vga_timing_ctrl #(.CLK_DIV(1)) dut_div1 (
      .clk(clk), .rst(rst), .rgb_in(rgb_in), .pix_x(ox[2]), .pix_y(oy[2]),
      .pix_req(oreq[2]), .pix_tick(otick[2]), .hsync(ohs[2]), .vsync(ovs[2]),
      .rgb_out(orgb[2]), .frame_start(ofs[2]));

   // Raster position after n pixel ticks, straight from the timing rules
   function automatic pos_t pos_at(input tp_t p, input int n);
      pos_t r;
      int ht, vt;
      ht = p.ha + p.hf + p.hs + p.hb;
      vt = p.va + p.vf + p.vs + p.vb;
      r.h    = n % ht;
      r.v    = (n / ht) % vt;
      r.req  = (r.h < p.ha) && (r.v < p.va);
      r.hraw = (r.h >= p.ha + p.hf) && (r.h < p.ha + p.hf + p.hs);
      r.vraw = (r.v >= p.va + p.vf) && (r.v < p.va + p.vf + p.vs);
      return r;
   endfunction

   // Hold reset over a few edges; returns at a negedge with rst still high
   task automatic apply_reset();
      rst    = 1'b1;
      rgb_in = 12'($urandom);
      repeat (3) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      apply_reset();
      total++; if (ox[0] !== 10'd0)     begin bad++; $display("FAIL reset_pix_x got=%0d exp=0", ox[0]); end
      total++; if (oy[0] !== 9'd0)      begin bad++; $display("FAIL reset_pix_y got=%0d exp=0", oy[0]); end
      total++; if (oreq[0] !== 1'b1)    begin bad++; $display("FAIL reset_pix_req got=%b exp=1", oreq[0]); end
      total++; if (otick[0] !== 1'b0)   begin bad++; $display("FAIL reset_pix_tick got=%b exp=0", otick[0]); end
      total++; if (ohs[0] !== 1'b1)     begin bad++; $display("FAIL reset_hsync got=%b exp=1", ohs[0]); end
      total++; if (ovs[0] !== 1'b1)     begin bad++; $display("FAIL reset_vsync got=%b exp=1", ovs[0]); end
      total++; if (orgb[0] !== 12'h000) begin bad++; $display("FAIL reset_rgb got=%h exp=000", orgb[0]); end
      total++; if (ofs[0] !== 1'b0)     begin bad++; $display("FAIL reset_frame_start got=%b exp=0", ofs[0]); end
   endtask

   // Standard timing: reset release, two full lines of random colour
   task automatic test_release_line();
      pos_t m;
      int n, first_tick, first_low, low_ticks;
      bit tk;
      logic [11:0] exp_rgb;
      logic exp_hs, exp_vs;
      exp_rgb = '0; exp_hs = 1'b1; exp_vs = 1'b1;
      first_tick = -1; first_low = -1; low_ticks = 0;
      apply_reset();
      for (int c = 0; c < 2 * 800 * 4; c++) begin
         if (c > 0) @(negedge clk);
         rst = 1'b0;
         n  = c / P_FULL.d;
         tk = (c % P_FULL.d) == P_FULL.d - 1;
         m  = pos_at(P_FULL, n);
         total++; if (otick[0] !== tk) begin bad++; $display("FAIL line_tick c=%0d got=%b exp=%b", c, otick[0], tk); end
         total++; if (ox[0] !== 10'(m.req ? m.h : 0)) begin bad++; $display("FAIL line_pix_x c=%0d got=%0d exp=%0d", c, ox[0], m.req ? m.h : 0); end
         total++; if (orgb[0] !== exp_rgb) begin bad++; $display("FAIL line_rgb c=%0d got=%h exp=%h", c, orgb[0], exp_rgb); end
         total++; if (ohs[0] !== exp_hs) begin bad++; $display("FAIL line_hsync c=%0d got=%b exp=%b", c, ohs[0], exp_hs); end
         total++; if (ovs[0] !== exp_vs) begin bad++; $display("FAIL line_vsync c=%0d got=%b exp=%b", c, ovs[0], exp_vs); end
         if (tk && first_tick < 0) first_tick = c;
         if (tk && ohs[0] === 1'b0) begin
            low_ticks++;
            if (first_low < 0) first_low = n;
         end
         rgb_in = 12'($urandom);
         if (tk) begin
            exp_rgb = m.req ? rgb_in : 12'h000;
            exp_hs  = ~m.hraw;
            exp_vs  = ~m.vraw;
         end
      end
      total++; if (first_tick != 3)  begin bad++; $display("FAIL first_tick_cycle got=%0d exp=3", first_tick); end
      total++; if (first_low != 657) begin bad++; $display("FAIL hsync_start_tick got=%0d exp=657", first_low); end
      total++; if (low_ticks != 192) begin bad++; $display("FAIL hsync_low_ticks got=%0d exp=192", low_ticks); end
   endtask

   // Shrunk timing: two whole frames with the coordinate colour pattern
   task automatic test_frame();
      pos_t m;
      int n, hh, vv, fs_cnt, fs_first, vs_low, hs_falls;
      bit tk, efs;
      logic prev_hs;
      logic [11:0] exp_rgb;
      logic exp_hs, exp_vs;
      exp_rgb = '0; exp_hs = 1'b1; exp_vs = 1'b1; prev_hs = 1'b1;
      fs_cnt = 0; fs_first = -1; vs_low = 0; hs_falls = 0;
      apply_reset();
      for (int c = 0; c < 2 * 425 * 2 + 20; c++) begin
         if (c > 0) @(negedge clk);
         rst = 1'b0;
         n   = c / P_SMALL.d;
         tk  = (c % P_SMALL.d) == P_SMALL.d - 1;
         m   = pos_at(P_SMALL, n);
         efs = tk && (m.h == 24) && (m.v == 16);
         total++; if (otick[1] !== tk) begin bad++; $display("FAIL frame_tick c=%0d got=%b exp=%b", c, otick[1], tk); end
         total++; if (oreq[1] !== m.req) begin bad++; $display("FAIL frame_req c=%0d got=%b exp=%b", c, oreq[1], m.req); end
         total++; if (ox[1] !== 10'(m.req ? m.h : 0)) begin bad++; $display("FAIL frame_pix_x c=%0d got=%0d exp=%0d", c, ox[1], m.req ? m.h : 0); end
         total++; if (oy[1] !== 9'(m.req ? m.v : 0)) begin bad++; $display("FAIL frame_pix_y c=%0d got=%0d exp=%0d", c, oy[1], m.req ? m.v : 0); end
         total++; if (orgb[1] !== exp_rgb) begin bad++; $display("FAIL frame_rgb c=%0d got=%h exp=%h", c, orgb[1], exp_rgb); end
         total++; if (ohs[1] !== exp_hs) begin bad++; $display("FAIL frame_hsync c=%0d got=%b exp=%b", c, ohs[1], exp_hs); end
         total++; if (ovs[1] !== exp_vs) begin bad++; $display("FAIL frame_vsync c=%0d got=%b exp=%b", c, ovs[1], exp_vs); end
         total++; if (ofs[1] !== efs) begin bad++; $display("FAIL frame_start c=%0d got=%b exp=%b", c, ofs[1], efs); end
         if (ofs[1] === 1'b1) begin
            fs_cnt++;
            if (fs_first < 0) fs_first = c;
         end
         if (tk && ovs[1] === 1'b0) vs_low++;
         if (prev_hs === 1'b1 && ohs[1] === 1'b0) hs_falls++;
         prev_hs = ohs[1];
         // picture generator role: colour is a function of the coordinates
         rgb_in = {oy[1][3:0], ox[1][7:0]};
         if (tk) begin
            hh = m.h; vv = m.v;
            exp_rgb = m.req ? {vv[3:0], hh[7:0]} : 12'h000;
            exp_hs  = ~m.hraw;
            exp_vs  = ~m.vraw;
         end
      end
      total++; if (fs_cnt != 2)     begin bad++; $display("FAIL frame_start_count got=%0d exp=2", fs_cnt); end
      total++; if (fs_first != 849) begin bad++; $display("FAIL frame_start_first got=%0d exp=849", fs_first); end
      total++; if (vs_low != 100)   begin bad++; $display("FAIL vsync_low_ticks got=%0d exp=100", vs_low); end
      total++; if (hs_falls != 34)  begin bad++; $display("FAIL hsync_pulses got=%0d exp=34", hs_falls); end
   endtask

   // CLK_DIV = 1: tick stuck high, line period 800 clks
   task automatic test_div1();
      int fall0, fall1;
      logic prev_hs;
      fall0 = -1; fall1 = -1; prev_hs = 1'b1;
      apply_reset();
      for (int c = 0; c < 1700; c++) begin
         if (c > 0) @(negedge clk);
         rst = 1'b0;
         total++; if (otick[2] !== 1'b1) begin bad++; $display("FAIL div1_tick c=%0d got=%b exp=1", c, otick[2]); end
         if (prev_hs === 1'b1 && ohs[2] === 1'b0) begin
            if (fall0 < 0) fall0 = c;
            else if (fall1 < 0) fall1 = c;
         end
         prev_hs = ohs[2];
         rgb_in = 12'($urandom);
      end
      total++; if (fall0 != 657)        begin bad++; $display("FAIL div1_hsync_start got=%0d exp=657", fall0); end
      total++; if (fall1 - fall0 != 800) begin bad++; $display("FAIL div1_line_period got=%0d exp=800", fall1 - fall0); end
   endtask

   // Reset in the middle of a frame: fixed point inside hsync, then random
   task automatic test_midframe_reset();
      pos_t m;
      int tgt, n;
      bit tk;
      logic [11:0] exp_rgb;
      logic exp_hs;
      for (int it = 0; it < 2; it++) begin
         // iteration 0: h=19, v=5 with half a pixel period elapsed
         tgt = (it == 0) ? (5 * 25 + 19) * 2 + 1 : int'($urandom_range(2, 849));
         apply_reset();
         for (int c = 0; c < tgt; c++) begin
            if (c > 0) @(negedge clk);
            rst = 1'b0;
            rgb_in = 12'($urandom);
         end
         @(negedge clk);
         if (it == 0) begin
            total++; if (ohs[1] !== 1'b0) begin bad++; $display("FAIL midrst_pre_hsync got=%b exp=0", ohs[1]); end
         end
         rst = 1'b1;
         @(negedge clk);
         total++; if (ohs[1] !== 1'b1)     begin bad++; $display("FAIL midrst_hsync it=%0d got=%b exp=1", it, ohs[1]); end
         total++; if (ovs[1] !== 1'b1)     begin bad++; $display("FAIL midrst_vsync it=%0d got=%b exp=1", it, ovs[1]); end
         total++; if (ox[1] !== 10'd0)     begin bad++; $display("FAIL midrst_pix_x it=%0d got=%0d exp=0", it, ox[1]); end
         total++; if (oy[1] !== 9'd0)      begin bad++; $display("FAIL midrst_pix_y it=%0d got=%0d exp=0", it, oy[1]); end
         total++; if (orgb[1] !== 12'h000) begin bad++; $display("FAIL midrst_rgb it=%0d got=%h exp=000", it, orgb[1]); end
         // raster must resume from (0,0) with a fresh pixel period
         exp_rgb = '0; exp_hs = 1'b1;
         for (int c = 0; c < 80; c++) begin
            if (c > 0) @(negedge clk);
            rst = 1'b0;
            n  = c / P_SMALL.d;
            tk = (c % P_SMALL.d) == P_SMALL.d - 1;
            m  = pos_at(P_SMALL, n);
            total++; if (otick[1] !== tk) begin bad++; $display("FAIL resume_tick c=%0d got=%b exp=%b", c, otick[1], tk); end
            total++; if (ox[1] !== 10'(m.req ? m.h : 0)) begin bad++; $display("FAIL resume_pix_x c=%0d got=%0d exp=%0d", c, ox[1], m.req ? m.h : 0); end
            total++; if (oy[1] !== 9'(m.req ? m.v : 0)) begin bad++; $display("FAIL resume_pix_y c=%0d got=%0d exp=%0d", c, oy[1], m.req ? m.v : 0); end
            total++; if (orgb[1] !== exp_rgb) begin bad++; $display("FAIL resume_rgb c=%0d got=%h exp=%h", c, orgb[1], exp_rgb); end
            total++; if (ohs[1] !== exp_hs) begin bad++; $display("FAIL resume_hsync c=%0d got=%b exp=%b", c, ohs[1], exp_hs); end
            rgb_in = 12'($urandom);
            if (tk) begin
               exp_rgb = m.req ? rgb_in : 12'h000;
               exp_hs  = ~m.hraw;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_release_line();
      test_frame();
      test_div1();
      test_midframe_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
